// File: rtl/lap_recorder.sv
// Lap recorder: captures stopwatch lap times into a circular buffer and
// muxes live or held/recalled time onto the display. Optional macro: LAP_SPLIT_EN.
module lap_recorder #(
  parameter int DEPTH       = 8,
  parameter int PTR_W       = 3,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             lap,
  input  logic             clear,
  input  logic [5:0]       hour_in,
  input  logic [5:0]       minute_in,
  input  logic [5:0]       second_in,
  input  logic [6:0]       m_sec_in,
  output logic [5:0]       hour_out,
  output logic [5:0]       minute_out,
  output logic [5:0]       second_out,
  output logic [6:0]       m_sec_out,
  output logic [PTR_W:0]   lap_count,
  output logic [PTR_W:0]   lap_index,
  output logic             showing_lap,
  output logic             overflow
);

  localparam int CNT_W   = PTR_W + 1;
  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {LIVE, HOLD, RECALL} state_t;

  state_t               state_reg;
  logic [PTR_W-1:0]     wp_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     idx_reg;
  logic                 overflow_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [24:0]          disp_reg;
  logic                 showing_reg;
  logic                 lap_prev_reg;
  logic                 clear_prev_reg;
  logic [24:0]          mem [DEPTH];

  logic                 lap_rise;
  logic                 clear_rise;
  logic [24:0]          live_word;
  logic                 capture_req;
  logic                 commit;
  logic [24:0]          commit_word;
  logic                 buffer_full;
  logic [CNT_W-1:0]     next_idx;
  logic [PTR_W-1:0]     rd_addr;

  assign lap_rise    = lap & ~lap_prev_reg;
  assign clear_rise  = clear & ~clear_prev_reg;
  assign live_word   = {hour_in, minute_in, second_in, m_sec_in};
  assign capture_req = lap_rise & run & ((state_reg == LIVE) || (state_reg == HOLD));
  assign buffer_full = (count_reg == CNT_W'(DEPTH));
  // Index shown after this edge when entering or stepping through RECALL.
  assign next_idx    = (state_reg == RECALL) ? idx_reg + 1'b1 : CNT_W'(1);
  assign rd_addr     = wp_reg - PTR_W'(next_idx);

`ifdef LAP_SPLIT_EN
  logic        pend_reg;
  logic [24:0] split_reg;
  logic [24:0] prev_cap_reg;

  // Mixed-radix a - b: hundredths base 100, seconds/minutes base 60, hours mod 64.
  function automatic logic [24:0] split_diff(input logic [24:0] a, input logic [24:0] b);
    logic       b_ms, b_s, b_m;
    logic [6:0] ms;
    logic [5:0] s, m, h;
    b_ms = a[6:0] < b[6:0];
    ms   = a[6:0] + (b_ms ? 7'd100 : 7'd0) - b[6:0];
    b_s  = {1'b0, a[12:7]} < ({1'b0, b[12:7]} + {6'd0, b_ms});
    s    = a[12:7] + (b_s ? 6'd60 : 6'd0) - b[12:7] - {5'd0, b_ms};
    b_m  = {1'b0, a[18:13]} < ({1'b0, b[18:13]} + {6'd0, b_s});
    m    = a[18:13] + (b_m ? 6'd60 : 6'd0) - b[18:13] - {5'd0, b_s};
    h    = a[24:19] - b[24:19] - {5'd0, b_m};
    return {h, m, s, ms};
  endfunction

  assign commit      = pend_reg;
  assign commit_word = split_reg;
`else
  assign commit      = capture_req;
  assign commit_word = live_word;
`endif

  always_ff @(posedge clock) begin
    if (commit && !clear_rise) begin
      mem[wp_reg] <= commit_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= LIVE;
      wp_reg         <= '0;
      count_reg      <= '0;
      idx_reg        <= '0;
      overflow_reg   <= 1'b0;
      timer_reg      <= '0;
      disp_reg       <= '0;
      showing_reg    <= 1'b0;
      lap_prev_reg   <= lap;
      clear_prev_reg <= clear;
`ifdef LAP_SPLIT_EN
      pend_reg       <= 1'b0;
      split_reg      <= '0;
      prev_cap_reg   <= '0;
`endif
    end else begin
      lap_prev_reg   <= lap;
      clear_prev_reg <= clear;
`ifdef LAP_SPLIT_EN
      pend_reg <= capture_req & ~clear_rise;
      if (capture_req && !clear_rise) begin
        split_reg    <= split_diff(live_word, prev_cap_reg);
        prev_cap_reg <= live_word;
      end
`endif
      if (clear_rise) begin
        state_reg    <= LIVE;
        wp_reg       <= '0;
        count_reg    <= '0;
        idx_reg      <= '0;
        overflow_reg <= 1'b0;
        timer_reg    <= '0;
        disp_reg     <= live_word;
        showing_reg  <= 1'b0;
`ifdef LAP_SPLIT_EN
        prev_cap_reg <= '0;
`endif
      end else if (commit) begin
        state_reg    <= HOLD;
        wp_reg       <= wp_reg + 1'b1;
        count_reg    <= buffer_full ? count_reg : count_reg + 1'b1;
        overflow_reg <= overflow_reg | buffer_full;
        timer_reg    <= TIMER_W'(HOLD_CYCLES - 1);
        idx_reg      <= CNT_W'(1);
        disp_reg     <= commit_word;
        showing_reg  <= 1'b1;
      end else begin
        case (state_reg)
          LIVE: begin
            if (lap_rise && !run && count_reg != '0) begin
              state_reg   <= RECALL;
              idx_reg     <= next_idx;
              disp_reg    <= mem[rd_addr];
              showing_reg <= 1'b1;
            end else begin
              disp_reg    <= live_word;
            end
          end
          HOLD: begin
            if (timer_reg == '0) begin
              state_reg   <= LIVE;
              idx_reg     <= '0;
              disp_reg    <= live_word;
              showing_reg <= 1'b0;
            end else begin
              timer_reg   <= timer_reg - 1'b1;
            end
          end
          RECALL: begin
            // Stepping past the oldest stored lap drops back to live time.
            if (run || (lap_rise && next_idx > count_reg)) begin
              state_reg   <= LIVE;
              idx_reg     <= '0;
              disp_reg    <= live_word;
              showing_reg <= 1'b0;
            end else if (lap_rise) begin
              idx_reg     <= next_idx;
              disp_reg    <= mem[rd_addr];
            end
          end
          default: begin
            state_reg   <= LIVE;
            idx_reg     <= '0;
            showing_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hour_out    = disp_reg[24:19];
  assign minute_out  = disp_reg[18:13];
  assign second_out  = disp_reg[12:7];
  assign m_sec_out   = disp_reg[6:0];
  assign lap_count   = count_reg;
  assign lap_index   = idx_reg;
  assign showing_lap = showing_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder; scoreboard queue of expected display words.
module tb_lap_recorder;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int HOLD  = 16;
`ifdef LAP_SPLIT_EN
  localparam int HOLD_SEEN = HOLD;
`else
  localparam int HOLD_SEEN = HOLD - 1;
`endif

  logic clock = 1'b0;
  logic reset, run, lap, clear;
  logic [5:0] hour_in, minute_in, second_in;
  logic [6:0] m_sec_in;
  logic [5:0] hour_out, minute_out, second_out;
  logic [6:0] m_sec_out;
  logic [PTR_W:0] lap_count, lap_index;
  logic showing_lap, overflow;

  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];
  logic [24:0] laps[$];
  logic [24:0] prev_cap = '0;

  lap_recorder #(.DEPTH(DEPTH), .PTR_W(PTR_W), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .run(run), .lap(lap), .clear(clear),
    .hour_in(hour_in), .minute_in(minute_in), .second_in(second_in), .m_sec_in(m_sec_in),
    .hour_out(hour_out), .minute_out(minute_out), .second_out(second_out), .m_sec_out(m_sec_out),
    .lap_count(lap_count), .lap_index(lap_index), .showing_lap(showing_lap), .overflow(overflow)
  );

  always #5 clock = ~clock;

  wire [24:0] dut_word = {hour_out, minute_out, second_out, m_sec_out};

  function automatic logic [24:0] mk(int h, int m, int s, int ms);
    return {6'(h), 6'(m), 6'(s), 7'(ms)};
  endfunction

`ifdef LAP_SPLIT_EN
  // Difference computed via total hundredths, wrapped at 64 hours.
  function automatic logic [24:0] split_of(logic [24:0] a, logic [24:0] b);
    int ta, tb, d;
    ta = int'(a[24:19]) * 360000 + int'(a[18:13]) * 6000 + int'(a[12:7]) * 100 + int'(a[6:0]);
    tb = int'(b[24:19]) * 360000 + int'(b[18:13]) * 6000 + int'(b[12:7]) * 100 + int'(b[6:0]);
    d = ta - tb;
    if (d < 0) d += 64 * 360000;
    return mk(d / 360000, (d / 6000) % 60, (d / 100) % 60, d % 100);
  endfunction
`endif

  function automatic logic [24:0] model_capture(logic [24:0] w);
    logic [24:0] stored;
`ifdef LAP_SPLIT_EN
    stored = split_of(w, prev_cap);
`else
    stored = w;
`endif
    prev_cap = w;
    laps.push_back(stored);
    return stored;
  endfunction

  function automatic void model_clear();
    laps.delete();
    prev_cap = '0;
  endfunction

  function automatic int model_count();
    return (laps.size() > DEPTH) ? DEPTH : laps.size();
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(int h, int m, int s, int ms);
    {hour_in, minute_in, second_in, m_sec_in} = mk(h, m, s, ms);
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    tick();
    lap = 1'b0;
    tick();
  endtask

  task automatic wait_live();
    for (int i = 0; i < 100 && showing_lap; i++) tick();
    checks++;
    if (showing_lap !== 1'b0) begin
      errors++;
      $display("FAIL wait_live: showing_lap=%0b still high, required 0", showing_lap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; lap = 1'b1; run = 1'b1; clear = 1'b0;
    set_time(0, 0, 5, 0);
    tick(); tick();
    checks++;
    if (dut_word !== 25'd0 || lap_count !== '0 || showing_lap !== 1'b0 ||
        lap_index !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: word=%h cnt=%0d show=%0b idx=%0d ovf=%0b, required all 0",
               dut_word, lap_count, showing_lap, lap_index, overflow);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_word !== mk(0, 0, 5, 0) || lap_count !== '0 || showing_lap !== 1'b0) begin
      errors++;
      $display("FAIL reset_lap_held: word=%h cnt=%0d show=%0b, required %h 0 0",
               dut_word, lap_count, showing_lap, mk(0, 0, 5, 0));
    end
    set_time(0, 0, 6, 7);
    checks++;
    if (dut_word !== mk(0, 0, 5, 0)) begin
      errors++;
      $display("FAIL live_latency_old: word=%h required %h", dut_word, mk(0, 0, 5, 0));
    end
    tick();
    checks++;
    if (dut_word !== mk(0, 0, 6, 7)) begin
      errors++;
      $display("FAIL live_track: word=%h required %h", dut_word, mk(0, 0, 6, 7));
    end
    lap = 1'b0;
    tick();
    $display("reset done: lap_count=%0d word=%h", lap_count, dut_word);
  endtask

  task automatic test_capture();
    logic [24:0] exp_w;
    int n;
    bit frozen;
    run = 1'b1;
    set_time(0, 1, 2, 34);
    exp_q.push_back(model_capture(mk(0, 1, 2, 34)));
    pulse_lap();
    set_time(0, 1, 3, 0);
    exp_w = exp_q.pop_front();
    checks++;
    if (dut_word !== exp_w || lap_count !== 4'd1 || showing_lap !== 1'b1 || lap_index !== 4'd1) begin
      errors++;
      $display("FAIL capture: word=%h cnt=%0d show=%0b idx=%0d, required %h 1 1 1",
               dut_word, lap_count, showing_lap, lap_index, exp_w);
    end
    $display("capture: word=%h lap_count=%0d", dut_word, lap_count);
    n = 1;
    frozen = 1'b1;
    for (int i = 0; i < 40 && showing_lap; i++) begin
      tick();
      if (showing_lap) begin
        n++;
        if (dut_word !== exp_w) frozen = 1'b0;
      end
    end
    checks++;
    if (n != HOLD_SEEN) begin
      errors++;
      $display("FAIL hold_length: %0d cycles seen, required %0d", n, HOLD_SEEN);
    end
    checks++;
    if (!frozen) begin
      errors++;
      $display("FAIL hold_frozen: display moved during hold, required %h", exp_w);
    end
    checks++;
    if (dut_word !== mk(0, 1, 3, 0) || lap_index !== '0) begin
      errors++;
      $display("FAIL hold_to_live: word=%h idx=%0d, required %h 0", dut_word, lap_index, mk(0, 1, 3, 0));
    end
  endtask

  task automatic test_overflow();
    logic [24:0] exp_w;
    clear = 1'b1; tick(); clear = 1'b0; tick();
    model_clear();
    checks++;
    if (lap_count !== '0) begin
      errors++;
      $display("FAIL clear_count: cnt=%0d required 0", lap_count);
    end
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_time(0, i, i + 1, i * 11);
      exp_q.push_back(model_capture(mk(0, i, i + 1, i * 11)));
      pulse_lap();
      exp_w = exp_q.pop_front();
      checks++;
      if (dut_word !== exp_w) begin
        errors++;
        $display("FAIL capture_%0d: word=%h required %h", i, dut_word, exp_w);
      end
      $display("capture %0d: word=%h lap_count=%0d", i, dut_word, lap_count);
    end
    checks++;
    if (lap_count !== 4'(model_count()) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: cnt=%0d ovf=%0b, required %0d 1", lap_count, overflow, model_count());
    end
    run = 1'b0;
    wait_live();
    for (int k = 1; k <= DEPTH; k++) begin
      exp_q.push_back(laps[laps.size() - k]);
      pulse_lap();
      exp_w = exp_q.pop_front();
      checks++;
      if (dut_word !== exp_w || lap_index !== 4'(k) || showing_lap !== 1'b1) begin
        errors++;
        $display("FAIL recall_%0d: word=%h idx=%0d show=%0b, required %h %0d 1",
                 k, dut_word, lap_index, showing_lap, exp_w, k);
      end
      $display("recall %0d: word=%h", k, dut_word);
    end
    pulse_lap();
    checks++;
    if (lap_index !== '0 || showing_lap !== 1'b0) begin
      errors++;
      $display("FAIL recall_wrap: idx=%0d show=%0b, required 0 0", lap_index, showing_lap);
    end
  endtask

  task automatic test_clear_lap();
    run = 1'b1;
    set_time(0, 9, 9, 9);
    exp_q.push_back(model_capture(mk(0, 9, 9, 9)));
    pulse_lap();
    void'(exp_q.pop_front());
    checks++;
    if (showing_lap !== 1'b1 || overflow !== 1'b1 || lap_count !== 4'(model_count())) begin
      errors++;
      $display("FAIL pre_clear: show=%0b ovf=%0b cnt=%0d, required 1 1 %0d",
               showing_lap, overflow, lap_count, model_count());
    end
    clear = 1'b1; lap = 1'b1;
    tick();
    model_clear();
    checks++;
    if (lap_count !== '0 || overflow !== 1'b0 || showing_lap !== 1'b0 || lap_index !== '0) begin
      errors++;
      $display("FAIL clear_lap: cnt=%0d ovf=%0b show=%0b idx=%0d, required 0 0 0 0",
               lap_count, overflow, showing_lap, lap_index);
    end
    clear = 1'b0; lap = 1'b0;
    tick(); tick();
    checks++;
    if (lap_count !== '0 || showing_lap !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_capture: cnt=%0d show=%0b, required 0 0", lap_count, showing_lap);
    end
    $display("clear+lap: lap_count=%0d overflow=%0b", lap_count, overflow);
  endtask

  task automatic test_recall_run();
    logic [24:0] exp_w;
    run = 1'b1;
    set_time(1, 2, 3, 4);
    void'(model_capture(mk(1, 2, 3, 4)));
    pulse_lap();
    set_time(1, 2, 5, 6);
    void'(model_capture(mk(1, 2, 5, 6)));
    pulse_lap();
    wait_live();
    run = 1'b0;
    pulse_lap();
    exp_q.push_back(laps[laps.size() - 2]);
    pulse_lap();
    exp_w = exp_q.pop_front();
    checks++;
    if (dut_word !== exp_w || lap_index !== 4'd2) begin
      errors++;
      $display("FAIL recall_idx2: word=%h idx=%0d, required %h 2", dut_word, lap_index, exp_w);
    end
    run = 1'b1;
    set_time(2, 0, 0, 0);
    tick();
    checks++;
    if (lap_index !== '0 || showing_lap !== 1'b0 || dut_word !== mk(2, 0, 0, 0) || lap_count !== 4'd2) begin
      errors++;
      $display("FAIL recall_run: idx=%0d show=%0b word=%h cnt=%0d, required 0 0 %h 2",
               lap_index, showing_lap, dut_word, lap_count, mk(2, 0, 0, 0));
    end
    $display("recall->run: lap_index=%0d word=%h", lap_index, dut_word);
  endtask

`ifdef LAP_SPLIT_EN
  task automatic test_split();
    logic [24:0] exp_w;
    clear = 1'b1; tick(); clear = 1'b0; tick();
    model_clear();
    run = 1'b1;
    set_time(0, 0, 59, 90);
    pulse_lap();
    set_time(0, 1, 0, 5);
    exp_q.push_back(mk(0, 0, 0, 15));
    pulse_lap();
    exp_w = exp_q.pop_front();
    checks++;
    if (dut_word !== exp_w) begin
      errors++;
      $display("FAIL split_hold: word=%h required %h", dut_word, exp_w);
    end
    wait_live();
    run = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 15));
    exp_q.push_back(mk(0, 0, 59, 90));
    for (int k = 1; k <= 2; k++) begin
      pulse_lap();
      exp_w = exp_q.pop_front();
      checks++;
      if (dut_word !== exp_w) begin
        errors++;
        $display("FAIL split_recall_%0d: word=%h required %h", k, dut_word, exp_w);
      end
      $display("split recall %0d: word=%h", k, dut_word);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_clear_lap();
    test_recall_run();
`ifdef LAP_SPLIT_EN
    test_split();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
